// File: rtl/mk_design_queue_check.sv
// ---------------------------------------------------------------------------
// mk_design_queue_check
//   Operand-pair queue with a "variable" sub-interface. start(a,b) pushes a
//   pair into a DEPTH-entry circular buffer. result(c) and check(d) both look
//   at the head pair. check also pops it and counts nonzero check values in
//   a saturating 8-bit mismatch counter.
//
// Ports
//   CLK, RST_N                     clock (rising edge), async active-low reset
//   start_a, start_b, EN_start     enqueue an operand pair
//   RDY_start                      queue not full
//   variable__result_c             argument c of result
//   variable__result               head.a + head.b + c (mod 2^W)
//   RDY_variable__result           queue not empty
//   variable__check_d              argument d of check
//   EN_variable__check             dequeue the head this cycle
//   variable__check                head vs d per CHK_MODE (0: a-b-d, 1: a^b^d)
//   RDY_variable__check            queue not empty
//   variable__count                occupancy, 0..DEPTH
//   variable__mismatches           saturating count of nonzero fired checks
// ---------------------------------------------------------------------------
module mk_design_queue_check #(
    parameter int W        = 6,
    parameter int DEPTH    = 4,
    parameter int CHK_MODE = 0
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [W-1:0]               start_a,
    input  logic [W-1:0]               start_b,
    input  logic                       EN_start,
    output logic                       RDY_start,
    input  logic [W-1:0]               variable__result_c,
    output logic [W-1:0]               variable__result,
    output logic                       RDY_variable__result,
    input  logic [W-1:0]               variable__check_d,
    input  logic                       EN_variable__check,
    output logic [W-1:0]               variable__check,
    output logic                       RDY_variable__check,
    output logic [$clog2(DEPTH):0]     variable__count,
    output logic [7:0]                 variable__mismatches
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Storage and bookkeeping
    logic [W-1:0]  r_mem_a [DEPTH];
    logic [W-1:0]  r_mem_b [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_mismatches;

    logic          w_not_full;
    logic          w_not_empty;
    logic          w_fire_start;
    logic          w_fire_check;
    logic [W-1:0]  w_head_a;
    logic [W-1:0]  w_head_b;
    logic [W-1:0]  w_result;
    logic [W-1:0]  w_check;

    // Ready depends only on occupancy, never on any enable.
    assign w_not_full   = (r_count != FULL_CNT);
    assign w_not_empty  = (r_count != '0);
    assign w_fire_start = EN_start & w_not_full;
    assign w_fire_check = EN_variable__check & w_not_empty;

    assign w_head_a = r_mem_a[r_rd_ptr];
    assign w_head_b = r_mem_b[r_rd_ptr];

    // Data outputs are forced to 0 while the queue is empty so that stale
    // entries never leak out.
    always_comb begin
        w_result = '0;
        w_check  = '0;
        if (w_not_empty) begin
            w_result = w_head_a + w_head_b + variable__result_c;
            if (CHK_MODE == 0) begin
                w_check = w_head_a - w_head_b - variable__check_d;
            end else begin
                w_check = w_head_a ^ w_head_b ^ variable__check_d;
            end
        end
    end

    // Payload RAM: no reset needed, visibility is governed by the pointers
    // and the occupancy counter.
    always_ff @(posedge CLK) begin
        if (w_fire_start) begin
            r_mem_a[r_wr_ptr] <= start_a;
            r_mem_b[r_wr_ptr] <= start_b;
        end
    end

    // Pointers, occupancy and mismatch counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_mismatches <= '0;
        end else begin
            if (w_fire_start) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_fire_check) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                if ((w_check != '0) && (r_mismatches != 8'hFF)) begin
                    r_mismatches <= r_mismatches + 8'd1;
                end
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            if (w_fire_start && !w_fire_check) begin
                r_count <= r_count + CW'(1);
            end else if (w_fire_check && !w_fire_start) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign RDY_start            = w_not_full;
    assign RDY_variable__result = w_not_empty;
    assign RDY_variable__check  = w_not_empty;
    assign variable__result     = w_result;
    assign variable__check      = w_check;
    assign variable__count      = r_count;
    assign variable__mismatches = r_mismatches;

endmodule
